// File: rtl/hamming_counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// hamming_counter_ctrl_if
//   Command channel of the Hamming counter run controller. It carries a
//   valid/ready command handshake and the run configuration, which is sampled
//   when a START command is accepted.
//
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  command accepted when cmd_valid && cmd_ready
//   cmd_op     master->slave  00 START, 01 STOP, 10 PAUSE, 11 RESUME
//   cfg_total  master->slave  enabled cycles per run
//   cfg_on     master->slave  burst length in enabled cycles (0 = continuous)
//   cfg_off    master->slave  gap length between bursts (0 = no gap)
// -----------------------------------------------------------------------------
interface hamming_counter_ctrl_if #(
  parameter int LEN_W = 16,
  parameter int BST_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cfg_total;
  logic [BST_W-1:0] cfg_on;
  logic [BST_W-1:0] cfg_off;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cfg_total,
    output cfg_on,
    output cfg_off,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cfg_total,
    input  cfg_on,
    input  cfg_off,
    output cmd_ready
  );
endinterface

// File: rtl/hamming_counter_ctrl.sv
// -----------------------------------------------------------------------------
// hamming_counter_ctrl
//   Run controller for the 16-bit Hamming counter datapath. On START it clears
//   the counter, issues cfg_total enable cycles (optionally as cfg_on/cfg_off
//   bursts), captures the final counter value and pulses done.
//
//   clk         in   single clock, rising edge
//   rst         in   synchronous, active-high reset
//   cmd         if   command channel (slave side), see hamming_counter_ctrl_if
//   counter_in  in   counter value from the datapath
//   cnt_clr     out  one-cycle counter clear pulse
//   cnt_en      out  counter enable
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at end of run
//   result      out  counter_in captured in DONE, held until next capture
//   en_cycles   out  enable cycles issued in current/last run
// -----------------------------------------------------------------------------
module hamming_counter_ctrl #(
  parameter int LEN_W = 16,
  parameter int BST_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_counter_ctrl_if.slave  cmd,
  input  logic [CNT_W-1:0]       counter_in,
  output logic                   cnt_clr,
  output logic                   cnt_en,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       result,
  output logic [LEN_W-1:0]       en_cycles
);

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [BST_W-1:0] BST_ZERO = {BST_W{1'b0}};
  localparam logic [BST_W-1:0] BST_ONE  = {{(BST_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           norm_nxt;      // where RUN/GAP would go if no command intervened
  state_t           resume_state;  // RUN or GAP to return to after PAUSE
  logic [LEN_W-1:0] total;
  logic [BST_W-1:0] on_len;
  logic [BST_W-1:0] off_len;
  logic [BST_W-1:0] burst_cnt;
  logic [BST_W-1:0] gap_cnt;
  logic             ready;

  logic cmd_acc;
  logic op_start;
  logic op_stop;
  logic op_pause;
  logic op_resume;
  logic en_last;
  logic burst_hit;
  logic gap_last;

  assign cmd.cmd_ready = ready;

  assign cmd_acc   = cmd.cmd_valid && ready;
  assign op_start  = cmd_acc && (cmd.cmd_op == OP_START);
  assign op_stop   = cmd_acc && (cmd.cmd_op == OP_STOP);
  assign op_pause  = cmd_acc && (cmd.cmd_op == OP_PAUSE);
  assign op_resume = cmd_acc && (cmd.cmd_op == OP_RESUME);

  // This RUN cycle issues the final enable of the run.
  assign en_last   = ((en_cycles + LEN_ONE) == total);
  // This RUN cycle completes a burst; never true in continuous mode.
  assign burst_hit = (on_len != BST_ZERO) && ((burst_cnt + BST_ONE) == on_len);
  // This GAP cycle is the last idle cycle of the gap.
  assign gap_last  = ((gap_cnt + BST_ONE) == off_len);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; commands that do not apply to the current state fall through.
  always_comb begin
    norm_nxt  = state;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (op_start && (cmd.cfg_total != LEN_ZERO)) begin
          state_nxt = ST_CLEAR;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_RUN;
      end
      ST_RUN, ST_GAP: begin
        if (state == ST_RUN) begin
          if (en_last) begin
            norm_nxt = ST_DONE;
          end else if (burst_hit && (off_len != BST_ZERO)) begin
            norm_nxt = ST_GAP;
          end else begin
            norm_nxt = ST_RUN;
          end
        end else begin
          if (gap_last) begin
            norm_nxt = ST_RUN;
          end else begin
            norm_nxt = ST_GAP;
          end
        end
        // Completion beats PAUSE; the accepting cycle itself runs normally.
        if (op_stop) begin
          state_nxt = ST_DONE;
        end else if (op_pause && (norm_nxt != ST_DONE)) begin
          state_nxt = ST_PAUSE;
        end else begin
          state_nxt = norm_nxt;
        end
      end
      ST_PAUSE: begin
        if (op_stop) begin
          state_nxt = ST_DONE;
        end else if (op_resume) begin
          state_nxt = resume_state;
        end else begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
      ST_CLEAR: begin
        cnt_clr = 1'b1;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        ready  = 1'b1;
      end
      ST_GAP: begin
        ready = 1'b1;
      end
      ST_PAUSE: begin
        ready = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Run configuration, burst/gap counters, enable tally and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      total        <= LEN_ZERO;
      on_len       <= BST_ZERO;
      off_len      <= BST_ZERO;
      burst_cnt    <= BST_ZERO;
      gap_cnt      <= BST_ZERO;
      en_cycles    <= LEN_ZERO;
      result       <= {CNT_W{1'b0}};
      resume_state <= ST_RUN;
    end else begin
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_CLEAR) begin
            total     <= cmd.cfg_total;
            on_len    <= cmd.cfg_on;
            off_len   <= cmd.cfg_off;
            burst_cnt <= BST_ZERO;
            gap_cnt   <= BST_ZERO;
            en_cycles <= LEN_ZERO;
          end
        end
        ST_RUN: begin
          en_cycles <= en_cycles + LEN_ONE;
          burst_cnt <= burst_hit ? BST_ZERO : (burst_cnt + BST_ONE);
        end
        ST_GAP: begin
          gap_cnt <= gap_last ? BST_ZERO : (gap_cnt + BST_ONE);
        end
        ST_DONE: begin
          // The counter already reflects the final enable here.
          result <= counter_in;
        end
        default: begin
        end
      endcase
      // Remember where the interrupted RUN/GAP cycle would have led.
      if ((state_nxt == ST_PAUSE) && (state != ST_PAUSE)) begin
        resume_state <= norm_nxt;
      end
    end
  end

endmodule
